// File: rtl/axi_resp_pkg.sv
// Shared AXI response/burst encodings, responder FSM states and the NoC channel structs
// used by the memory responder and its peers.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 16;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_VALID
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     aw_id;
    logic [AXI_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [AXI_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    b_ready;
    logic [AXI_ID_W-1:0]     ar_id;
    logic [AXI_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_mosi_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
  } axi_miso_t;

endpackage

// File: rtl/sr_axi_ram.sv
// Word array with one byte-enabled write port and one registered read port.
// A read and a write to the same word in the same cycle return the old contents.
module sr_axi_ram #(
  parameter  int WORDS  = 1024,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sr_axi_mem_responder.sv
// AXI4 memory responder: independent write and read FSMs in front of an on-chip RAM,
// FIXED/INCR bursts (WRAP runs as INCR but reports SLVERR).
module sr_axi_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int ID_W_WIDTH     = AXI_ID_W,
  parameter int ID_R_WIDTH     = AXI_ID_W,
  parameter int MAX_ID_WIDTH   = AXI_ID_W,
  parameter int ADDR_WIDTH     = AXI_ADDR_W,
  parameter int AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int MEM_WORDS      = 1024
) (
  input  logic      clk,
  input  logic      rst_n,
  input  axi_mosi_t in_mosi_i,
  output axi_miso_t in_miso_o
);

  localparam int MEM_AW = $clog2(MEM_WORDS);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-3:0] idx);
    return (32'(idx) >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic fixed);
    return fixed ? a : a + ADDR_WIDTH'(4);
  endfunction

  // Write channel state
  wr_state_e               w_state_q, w_state_d;
  logic [ID_W_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]              wlen_q, wlen_d;
  logic                    wfixed_q, wfixed_d;
  logic [7:0]              wbeat_q, wbeat_d;
  logic                    werr_q, werr_d;
  logic                    awready_q, wready_q, bvalid_q;
  logic                    w_fire, w_last_beat, w_oob;

  // Read channel state
  rd_state_e               r_state_q, r_state_d;
  logic [ID_R_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [7:0]              rlen_q, rlen_d;
  logic                    rfixed_q, rfixed_d;
  logic [7:0]              rbeat_q, rbeat_d;
  logic                    rcfg_err_q, rcfg_err_d;
  logic                    roob_q, roob_d;
  logic                    arready_q, rvalid_q;
  logic                    r_fetch, r_last;

  logic [AXI_DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    w_state_d   = w_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wfixed_d    = wfixed_q;
    wbeat_d     = wbeat_q;
    werr_d      = werr_q;
    w_fire      = 1'b0;
    w_last_beat = (wbeat_q == wlen_q);
    w_oob       = out_of_range(waddr_q[ADDR_WIDTH-1:2]);
    unique case (w_state_q)
      W_IDLE: begin
        if (awready_q && in_mosi_i.aw_valid) begin
          awid_d    = in_mosi_i.aw_id[ID_W_WIDTH-1:0];
          waddr_d   = in_mosi_i.aw_addr[ADDR_WIDTH-1:0];
          wlen_d    = in_mosi_i.aw_len;
          wfixed_d  = (in_mosi_i.aw_burst == BURST_FIXED);
          wbeat_d   = 8'd0;
          werr_d    = (in_mosi_i.aw_size != SIZE_WORD) || (in_mosi_i.aw_burst == BURST_WRAP);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready_q && in_mosi_i.w_valid) begin
          w_fire  = 1'b1;
          werr_d  = werr_q || w_oob || (in_mosi_i.w_last != w_last_beat);
          waddr_d = next_addr(waddr_q, wfixed_q);
          wbeat_d = wbeat_q + 8'd1;
          // The beat count alone ends the burst; a wrong WLAST only flags an error.
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && in_mosi_i.b_ready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rfixed_d   = rfixed_q;
    rbeat_d    = rbeat_q;
    rcfg_err_d = rcfg_err_q;
    roob_d     = roob_q;
    r_fetch    = 1'b0;
    r_last     = (rbeat_q == rlen_q);
    unique case (r_state_q)
      R_IDLE: begin
        if (arready_q && in_mosi_i.ar_valid) begin
          rid_d      = in_mosi_i.ar_id[ID_R_WIDTH-1:0];
          raddr_d    = in_mosi_i.ar_addr[ADDR_WIDTH-1:0];
          rlen_d     = in_mosi_i.ar_len;
          rfixed_d   = (in_mosi_i.ar_burst == BURST_FIXED);
          rbeat_d    = 8'd0;
          rcfg_err_d = (in_mosi_i.ar_size != SIZE_WORD) || (in_mosi_i.ar_burst == BURST_WRAP);
          r_state_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        r_fetch   = 1'b1;
        roob_d    = out_of_range(raddr_q[ADDR_WIDTH-1:2]);
        r_state_d = R_VALID;
      end
      R_VALID: begin
        if (rvalid_q && in_mosi_i.r_ready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d   = next_addr(raddr_q, rfixed_q);
            rbeat_d   = rbeat_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      wbeat_q    <= 8'd0;
      werr_q     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      r_state_q  <= R_IDLE;
      rbeat_q    <= 8'd0;
      rcfg_err_q <= 1'b0;
      roob_q     <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      wbeat_q    <= wbeat_d;
      werr_q     <= werr_d;
      awready_q  <= (w_state_d == W_IDLE);
      wready_q   <= (w_state_d == W_DATA);
      bvalid_q   <= (w_state_d == W_RESP);
      r_state_q  <= r_state_d;
      rbeat_q    <= rbeat_d;
      rcfg_err_q <= rcfg_err_d;
      roob_q     <= roob_d;
      arready_q  <= (r_state_d == R_IDLE);
      rvalid_q   <= (r_state_d == R_VALID);
    end
  end

  always_ff @(posedge clk) begin
    awid_q   <= awid_d;
    waddr_q  <= waddr_d;
    wlen_q   <= wlen_d;
    wfixed_q <= wfixed_d;
    rid_q    <= rid_d;
    raddr_q  <= raddr_d;
    rlen_q   <= rlen_d;
    rfixed_q <= rfixed_d;
  end

  sr_axi_ram #(
    .WORDS  (MEM_WORDS),
    .DATA_W (AXI_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_fire && !w_oob),
    .waddr_i (waddr_q[MEM_AW+1:2]),
    .wdata_i (in_mosi_i.w_data),
    .wstrb_i (in_mosi_i.w_strb),
    .re_i    (r_fetch),
    .raddr_i (raddr_q[MEM_AW+1:2]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    in_miso_o          = '0;
    in_miso_o.aw_ready = awready_q;
    in_miso_o.w_ready  = wready_q;
    in_miso_o.b_valid  = bvalid_q;
    in_miso_o.b_id     = MAX_ID_WIDTH'(awid_q);
    in_miso_o.b_resp   = (bvalid_q && werr_q) ? RESP_SLVERR : RESP_OKAY;
    in_miso_o.ar_ready = arready_q;
    in_miso_o.r_valid  = rvalid_q;
    in_miso_o.r_id     = MAX_ID_WIDTH'(rid_q);
    in_miso_o.r_data   = (rvalid_q && !roob_q) ? ram_rdata : '0;
    in_miso_o.r_resp   = (rvalid_q && (rcfg_err_q || roob_q)) ? RESP_SLVERR : RESP_OKAY;
    in_miso_o.r_last   = rvalid_q && r_last;
  end

endmodule

// File: tb/tb_sr_axi_mem_responder.sv
// Directed bench for the AXI memory responder: a word-array model plus expected B/R queues,
// checked every cycle by one compare process, and a few literal end results.
module tb_sr_axi_mem_responder;
  import axi_resp_pkg::*;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic      clk = 1'b0;
  logic      rst_n;
  axi_mosi_t mosi;
  axi_miso_t miso;

  logic [31:0] mdl_mem [0:1023];
  logic [31:0] wd [0:7];
  b_exp_t      b_q[$];
  r_exp_t      r_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ar_cyc = 0;
  int first_rv_cyc = -1;
  int r_beats_seen = 0;

  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;
  logic [3:0]  last_rid, last_bid;
  logic        last_rlast;

  sr_axi_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_mosi_i (mosi),
    .in_miso_o (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, required none", name);
  endtask

  // Every cycle a response is offered it must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (miso.r_valid) begin
        if (r_q.size() == 0) begin
          flag("r_unexpected");
        end else begin
          chk("r_data", miso.r_data, r_q[0].data);
          chk("r_resp", 32'(miso.r_resp), 32'(r_q[0].resp));
          chk("r_last", 32'(miso.r_last), 32'(r_q[0].last));
          chk("r_id", 32'(miso.r_id), 32'(r_q[0].id));
          if (first_rv_cyc < 0) first_rv_cyc = cyc;
          if (mosi.r_ready) begin
            last_rdata = miso.r_data;
            last_rresp = miso.r_resp;
            last_rid   = miso.r_id;
            last_rlast = miso.r_last;
            r_beats_seen++;
            void'(r_q.pop_front());
          end
        end
      end
      if (miso.b_valid) begin
        chk("aw_ready_during_b", 32'(miso.aw_ready), 32'd0);
        if (b_q.size() == 0) begin
          flag("b_unexpected");
        end else begin
          chk("b_id", 32'(miso.b_id), 32'(b_q[0].id));
          chk("b_resp", 32'(miso.b_resp), 32'(b_q[0].resp));
          if (mosi.b_ready) begin
            last_bid   = miso.b_id;
            last_bresp = miso.b_resp;
            void'(b_q.pop_front());
          end
        end
      end
    end
  end

  task automatic write_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                             input int bad_last_beat, input int nsend, input int bready_delay);
    logic        err;
    logic [15:0] a;
    int          guard;
    int          idx;
    err = (size != 3'b010) || (burst == 2'b10);
    a = addr;
    mosi.b_ready  = 1'b0;
    mosi.aw_id    = id;
    mosi.aw_addr  = addr;
    mosi.aw_len   = len;
    mosi.aw_burst = burst;
    mosi.aw_size  = size;
    mosi.aw_valid = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!miso.aw_ready && guard < 50);
    if (!miso.aw_ready) flag("aw_timeout");
    @(posedge clk); #1;
    mosi.aw_valid = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      mosi.w_data  = wd[i];
      mosi.w_strb  = strb;
      mosi.w_last  = (i == int'(len)) ^ (i == bad_last_beat);
      mosi.w_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!miso.w_ready && guard < 50);
      if (!miso.w_ready) flag("w_timeout");
      idx = int'(a >> 2);
      if (idx >= 1024) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (strb[b]) mdl_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      if (mosi.w_last != (i == int'(len))) err = 1'b1;
      if (burst != 2'b00) a = a + 16'd4;
      @(posedge clk); #1;
    end
    mosi.w_valid = 1'b0;
    mosi.w_last  = 1'b0;
    if (nsend == int'(len) + 1) begin
      b_q.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
      repeat (bready_delay) begin @(posedge clk); #1; end
      mosi.b_ready = 1'b1;
      guard = 0;
      while (b_q.size() > 0 && guard < 100) begin @(negedge clk); guard++; end
      if (b_q.size() > 0) begin flag("b_timeout"); b_q.delete(); end
      @(posedge clk); #1;
      mosi.b_ready = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int stall);
    logic        cfg_err;
    logic [15:0] a;
    int          idx;
    int          guard;
    r_exp_t      e;
    cfg_err = (size != 3'b010) || (burst == 2'b10);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      idx    = int'(a >> 2);
      e.id   = id;
      e.data = (idx >= 1024) ? 32'd0 : mdl_mem[idx];
      e.resp = (cfg_err || idx >= 1024) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      r_q.push_back(e);
      if (burst != 2'b00) a = a + 16'd4;
    end
    first_rv_cyc  = -1;
    mosi.r_ready  = (stall == 0);
    mosi.ar_id    = id;
    mosi.ar_addr  = addr;
    mosi.ar_len   = len;
    mosi.ar_burst = burst;
    mosi.ar_size  = size;
    mosi.ar_valid = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!miso.ar_ready && guard < 50);
    if (!miso.ar_ready) flag("ar_timeout");
    ar_cyc = cyc;
    @(posedge clk); #1;
    mosi.ar_valid = 1'b0;
    guard = 0;
    while (r_q.size() > 0 && guard < 2000) begin
      mosi.r_ready = (guard >= stall);
      @(posedge clk); #1;
      guard++;
    end
    if (r_q.size() > 0) begin flag("r_timeout"); r_q.delete(); end
    mosi.r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats0;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = 32'd0;
    mosi  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 32'(miso.aw_ready), 32'd0);
    chk("rst_ar_ready", 32'(miso.ar_ready), 32'd0);
    chk("rst_w_ready", 32'(miso.w_ready), 32'd0);
    chk("rst_valids", {30'd0, miso.b_valid, miso.r_valid}, 32'd0);
    chk("rst_resps", {28'd0, miso.b_resp, miso.r_resp}, 32'd0);
    chk("rst_r_data", miso.r_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write then read, with read latency
    wd[0] = 32'hDEADBEEF;
    write_burst(4'd3, 16'h0010, 8'd0, BURST_INCR, SIZE_WORD, 4'hF, -1, 1, 0);
    chk("t1_bid", 32'(last_bid), 32'd3);
    chk("t1_bresp", 32'(last_bresp), 32'd0);
    read_burst(4'd5, 16'h0010, 8'd0, BURST_INCR, SIZE_WORD, 0);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    chk("t1_rid", 32'(last_rid), 32'd5);
    chk("t1_rlast", 32'(last_rlast), 32'd1);
    chk("t1_rresp", 32'(last_rresp), 32'd0);
    chk("t1_latency", 32'(first_rv_cyc - ar_cyc), 32'd2);

    // INCR burst of four
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    write_burst(4'd1, 16'h0100, 8'd3, BURST_INCR, SIZE_WORD, 4'hF, -1, 4, 0);
    beats0 = r_beats_seen;
    read_burst(4'd2, 16'h0100, 8'd3, BURST_INCR, SIZE_WORD, 0);
    chk("t2_beats", 32'(r_beats_seen - beats0), 32'd4);
    chk("t2_last_data", last_rdata, 32'd4);

    // Partial strobe
    wd[0] = 32'hFFFFFFFF;
    write_burst(4'd0, 16'h0200, 8'd0, BURST_INCR, SIZE_WORD, 4'hF, -1, 1, 0);
    wd[0] = 32'h11223344;
    write_burst(4'd0, 16'h0200, 8'd0, BURST_INCR, SIZE_WORD, 4'b0101, -1, 1, 0);
    read_burst(4'd0, 16'h0200, 8'd0, BURST_INCR, SIZE_WORD, 0);
    chk("t3_strobe", last_rdata, 32'hFF22FF44);

    // Out of range write/read, word 0 must not be aliased
    wd[0] = 32'hCAFEF00D;
    write_burst(4'd4, 16'h0000, 8'd0, BURST_INCR, SIZE_WORD, 4'hF, -1, 1, 0);
    wd[0] = 32'hAABBCCDD;
    write_burst(4'd4, 16'h1000, 8'd0, BURST_INCR, SIZE_WORD, 4'hF, -1, 1, 0);
    chk("t4_bresp", 32'(last_bresp), 32'd2);
    read_burst(4'd6, 16'h1000, 8'd0, BURST_INCR, SIZE_WORD, 0);
    chk("t4_rdata", last_rdata, 32'd0);
    chk("t4_rresp", 32'(last_rresp), 32'd2);
    read_burst(4'd6, 16'h0000, 8'd0, BURST_INCR, SIZE_WORD, 0);
    chk("t4_word0", last_rdata, 32'hCAFEF00D);

    // Backpressure on B and R
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    write_burst(4'd7, 16'h0300, 8'd3, BURST_INCR, SIZE_WORD, 4'hF, -1, 4, 5);
    @(negedge clk);
    chk("t5_aw_ready_after_b", 32'(miso.aw_ready), 32'd1);
    @(posedge clk); #1;
    beats0 = r_beats_seen;
    read_burst(4'd8, 16'h0300, 8'd3, BURST_INCR, SIZE_WORD, 7);
    chk("t5_beats", 32'(r_beats_seen - beats0), 32'd4);
    chk("t5_last_data", last_rdata, 32'hA3);

    // FIXED bursts, WRAP, bad size, WLAST mismatch, address wrap past 0xFFFC
    wd[0] = 32'h10; wd[1] = 32'h20; wd[2] = 32'h30;
    write_burst(4'd9, 16'h0400, 8'd2, BURST_FIXED, SIZE_WORD, 4'hF, -1, 3, 0);
    read_burst(4'd9, 16'h0400, 8'd1, BURST_FIXED, SIZE_WORD, 0);
    chk("t7_fixed", last_rdata, 32'h30);
    read_burst(4'd10, 16'h0100, 8'd1, BURST_WRAP, SIZE_WORD, 0);
    chk("t7_wrap_resp", 32'(last_rresp), 32'd2);
    wd[0] = 32'h55;
    write_burst(4'd11, 16'h0500, 8'd0, BURST_INCR, 3'b001, 4'hF, -1, 1, 0);
    chk("t7_size_bresp", 32'(last_bresp), 32'd2);
    wd[0] = 32'h61; wd[1] = 32'h62; wd[2] = 32'h63; wd[3] = 32'h64;
    write_burst(4'd12, 16'h0600, 8'd3, BURST_INCR, SIZE_WORD, 4'hF, 1, 4, 0);
    chk("t7_wlast_bresp", 32'(last_bresp), 32'd2);
    read_burst(4'd12, 16'h0600, 8'd3, BURST_INCR, SIZE_WORD, 0);
    wd[0] = 32'h77; wd[1] = 32'h88;
    write_burst(4'd13, 16'hFFFC, 8'd1, BURST_INCR, SIZE_WORD, 4'hF, -1, 2, 0);
    read_burst(4'd13, 16'h0000, 8'd0, BURST_INCR, SIZE_WORD, 0);
    chk("t7_addr_wrap", last_rdata, 32'h88);

    // Reset in the middle of a write burst
    wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
    write_burst(4'd14, 16'h0700, 8'd3, BURST_INCR, SIZE_WORD, 4'hF, -1, 2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ready", {29'd0, miso.aw_ready, miso.w_ready, miso.ar_ready}, 32'd0);
    chk("t6_rst_valid", {30'd0, miso.b_valid, miso.r_valid}, 32'd0);
    chk("t6_rst_resp", {28'd0, miso.b_resp, miso.r_resp}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wd[0] = 32'hC0; wd[1] = 32'hC1;
    write_burst(4'd15, 16'h0800, 8'd1, BURST_INCR, SIZE_WORD, 4'hF, -1, 2, 0);
    chk("t6_fresh_bresp", 32'(last_bresp), 32'd0);
    read_burst(4'd15, 16'h0700, 8'd1, BURST_INCR, SIZE_WORD, 0);
    chk("t6_committed_beat", last_rdata, 32'hB1);
    read_burst(4'd15, 16'h0800, 8'd1, BURST_INCR, SIZE_WORD, 0);
    chk("t6_fresh_rdata", last_rdata, 32'hC1);
    chk("t6_fresh_rresp", 32'(last_rresp), 32'd0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
